pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives STALL/FLUSH of IF, the IF/ID
//  register, ID/EX and EX/MEM from icache/dcache miss, load-use and branch-mispredict events.
//  Produces the fetch redirect and keeps saturating stall/flush perf counters.
// PARAMETERS
//  FLUSH_CYCLES   1    cycles FLUSH_IFID stays high after a mispredict (>=1)
//  MAX_MEM_WAIT   255  MEMWAIT cycles before sticky MemWait_Timeout sets
//  CNT_W          32   width of perf counters
// PORTS
//  CLK               in   1      clock, all state on posedge
//  RESET             in   1      synchronous, active-high reset
//  IF_Miss           in   1      icache has no instruction this cycle
//  MEM_Miss          in   1      dcache miss in MEM; held high until data returns
//  ID_LoadUse        in   1      ID instr needs result of load now in EX
//  EX_Mispredict     in   1      EX-resolved branch disagrees with prediction
//  EX_Redirect_Addr  in   32     correct next PC for the mispredicted branch
//  STALL_IF          out  1      hold PC/fetch
//  STALL_IFID        out  1      hold IF/ID register
//  FLUSH_IFID        out  1      zero IF/ID register (bubble into ID)
//  STALL_IDEX        out  1      hold ID/EX register
//  FLUSH_IDEX        out  1      zero ID/EX register (bubble into EX)
//  STALL_EXMEM       out  1      hold EX/MEM register
//  Redirect_Valid    out  1      load PC with Redirect_Addr this cycle
//  Redirect_Addr     out  32     redirect target
//  State_OUT         out  2      RUN=0, MEMWAIT=1, FLUSH=2
//  Stall_Count       out  CNT_W  cycles with STALL_IF=1
//  Flush_Count       out  CNT_W  number of redirects issued
//  MemWait_Timeout   out  1      sticky error flag
// BEHAVIOUR
//  - Control outputs are combinational from registered state + current inputs; state, counters
//    and flag update on posedge CLK. Zero-cycle latency event->control.
//  - RESET=1: next state RUN, wait/flush counters 0, Stall_Count=Flush_Count=0, Timeout=0.
//    While RESET=1 (overrides state): all STALL_*=0, FLUSH_IFID=FLUSH_IDEX=1, Redirect_Valid=0,
//    Redirect_Addr=0, State_OUT reflects reset state after the edge. Reset mid-MEMWAIT/FLUSH aborts.
//  - Priority each cycle: MEM_Miss > EX_Mispredict > ID_LoadUse > IF_Miss.
//  - RUN:
//    MEM_Miss: all four STALL_*=1, flushes 0, no redirect; next MEMWAIT, wait counter=0.
//    EX_Mispredict: FLUSH_IFID=FLUSH_IDEX=1, stalls 0, Redirect_Valid=1,
//      Redirect_Addr=EX_Redirect_Addr, Flush_Count+1; next FLUSH (cnt=FLUSH_CYCLES-1) if
//      FLUSH_CYCLES>1 else RUN. Concurrent ID_LoadUse/IF_Miss ignored.
//    ID_LoadUse: STALL_IF=STALL_IFID=1, FLUSH_IDEX=1, others 0; stay RUN.
//    IF_Miss only: STALL_IF=1, FLUSH_IFID=1, others 0; stay RUN.
//    none: all outputs 0.
//  - MEMWAIT: MEM_Miss=1 -> freeze as above, wait counter +1 (saturates); when it reaches
//    MAX_MEM_WAIT set MemWait_Timeout (sticky until RESET). EX_Mispredict ignored while frozen.
//    MEM_Miss=0 -> outputs evaluated exactly as RUN for this cycle, next state per RUN rules.
//  - FLUSH: MEM_Miss=1 -> freeze, cnt held, stay FLUSH. EX_Mispredict -> new redirect as in
//    RUN, cnt reloaded to FLUSH_CYCLES-1. Else FLUSH_IFID=1, STALL_IF=0, no redirect, cnt-1;
//    cnt==1 -> next RUN. ID_LoadUse/IF_Miss ignored in FLUSH.
//  - Stall_Count +1 every non-reset cycle STALL_IF=1; both counters saturate at all-ones.
//  - Redirect_Addr=0 whenever Redirect_Valid=0.
// TESTING
//  1 RESET 2 cycles -> flushes=1, stalls=0, counters 0, State_OUT=0; release -> all outputs 0.
//  2 EX_Mispredict=1, addr=0x00400120, FLUSH_CYCLES=1 -> same cycle FLUSH_IF/ID/EX=1,
//    Redirect 0x00400120, Flush_Count=1, State_OUT stays 0; FLUSH_CYCLES=3 -> FLUSH_IFID 2 more cycles.
//  3 ID_LoadUse for 1 cycle -> STALL_IF=STALL_IFID=FLUSH_IDEX=1 that cycle, Stall_Count=1.
//  4 MEM_Miss 5 cycles with EX_Mispredict+ID_LoadUse high -> all stalls 1, no redirect 5 cycles,
//    State_OUT=1 from cycle 2; on drop, mispredict redirect issued same cycle.
//  5 MAX_MEM_WAIT=4, MEM_Miss 10 cycles -> MemWait_Timeout=1 after 4th MEMWAIT cycle, stays after.
//  6 RESET asserted mid-MEMWAIT and mid-FLUSH -> next cycle State_OUT=0, Timeout/counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It turns icache/dcache
//   misses, load-use hazards and EX-resolved branch mispredicts into per-stage
//   STALL/FLUSH controls and a fetch redirect. It also keeps saturating perf
//   counters and a sticky dcache-wait timeout flag.
//
// Ports
//   CLK, RESET           clock; synchronous active-high reset
//   IF_Miss              icache has no instruction this cycle
//   MEM_Miss             dcache miss in MEM, held until data returns
//   ID_LoadUse           ID instruction depends on the load now in EX
//   EX_Mispredict        EX-resolved branch disagrees with the prediction
//   EX_Redirect_Addr     correct next PC for the mispredicted branch
//   STALL_IF/IFID/IDEX/EXMEM, FLUSH_IFID/IDEX   per-stage pipeline controls
//   Redirect_Valid/Addr  load the PC with Redirect_Addr this cycle
//   State_OUT            RUN=0, MEMWAIT=1, FLUSH=2
//   Stall_Count          cycles with STALL_IF=1 (saturating)
//   Flush_Count          redirects issued (saturating)
//   MemWait_Timeout      sticky: the dcache wait reached MAX_MEM_WAIT cycles

module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_MEM_WAIT = 255,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IF_Miss,
  input  logic             MEM_Miss,
  input  logic             ID_LoadUse,
  input  logic             EX_Mispredict,
  input  logic [31:0]      EX_Redirect_Addr,
  output logic             STALL_IF,
  output logic             STALL_IFID,
  output logic             FLUSH_IFID,
  output logic             STALL_IDEX,
  output logic             FLUSH_IDEX,
  output logic             STALL_EXMEM,
  output logic             Redirect_Valid,
  output logic [31:0]      Redirect_Addr,
  output logic [1:0]       State_OUT,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count,
  output logic             MemWait_Timeout
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam int WAIT_W = (MAX_MEM_WAIT < 2) ? 1 : $clog2(MAX_MEM_WAIT + 1);
  // The flush counter only ever holds FLUSH_CYCLES-1.
  localparam int FCNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_MEM_WAIT);
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
  // A single-cycle flush is fully covered by the mispredict cycle itself.
  localparam state_t MISP_NEXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                wait_hit;

  // State register, perf counters and the sticky timeout flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= RUN;
      wait_q          <= '0;
      fcnt_q          <= '0;
      Stall_Count     <= '0;
      Flush_Count     <= '0;
      MemWait_Timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fcnt_q  <= fcnt_d;
      if (STALL_IF && (Stall_Count != '1))
        Stall_Count <= Stall_Count + CNT_W'(1);
      if (Redirect_Valid && (Flush_Count != '1))
        Flush_Count <= Flush_Count + CNT_W'(1);
      if (wait_hit)
        MemWait_Timeout <= 1'b1;
    end
  end

  // Next-state logic. MEMWAIT without a miss behaves exactly like RUN, so the
  // two states share one branch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN, MEMWAIT: begin
        if (MEM_Miss) begin
          state_d = MEMWAIT;
          if (state_q == RUN)
            wait_d = '0;
          else if (wait_q != WAIT_MAX)
            wait_d = wait_q + WAIT_W'(1);
        end else if (EX_Mispredict) begin
          state_d = MISP_NEXT;
          fcnt_d  = FCNT_LOAD;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (!MEM_Miss) begin
          if (EX_Mispredict) begin
            fcnt_d = FCNT_LOAD;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
            if (fcnt_q <= FCNT_W'(1))
              state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // The timeout fires on the cycle the wait counter reaches its limit.
  assign wait_hit = (state_q == MEMWAIT) && MEM_Miss && (wait_d == WAIT_MAX);

  // Control outputs. A dcache miss freezes the whole pipe in every state and
  // masks a concurrent mispredict, because that branch is frozen in EX too.
  always_comb begin
    STALL_IF       = 1'b0;
    STALL_IFID     = 1'b0;
    FLUSH_IFID     = 1'b0;
    STALL_IDEX     = 1'b0;
    FLUSH_IDEX     = 1'b0;
    STALL_EXMEM    = 1'b0;
    Redirect_Valid = 1'b0;
    Redirect_Addr  = 32'd0;
    if (RESET) begin
      FLUSH_IFID = 1'b1;
      FLUSH_IDEX = 1'b1;
    end else if (MEM_Miss) begin
      STALL_IF    = 1'b1;
      STALL_IFID  = 1'b1;
      STALL_IDEX  = 1'b1;
      STALL_EXMEM = 1'b1;
    end else if (EX_Mispredict) begin
      FLUSH_IFID     = 1'b1;
      FLUSH_IDEX     = 1'b1;
      Redirect_Valid = 1'b1;
      Redirect_Addr  = EX_Redirect_Addr;
    end else if (state_q == FLUSH) begin
      // Wrong-path fetches keep being squashed. Fetch misses and load-use
      // hazards do not matter while the wrong path is being squashed.
      FLUSH_IFID = 1'b1;
    end else if (ID_LoadUse) begin
      STALL_IF   = 1'b1;
      STALL_IFID = 1'b1;
      FLUSH_IDEX = 1'b1;
    end else if (IF_Miss) begin
      STALL_IF   = 1'b1;
      FLUSH_IFID = 1'b1;
    end
  end

  assign State_OUT = state_q;

endmodule
